pll_reset_sequencer: RTL
========================

// Module: pll_reset_sequencer
// PURPOSE
//   Brings up the HDMI clock PLL and the design's resets from the 25 MHz board clock.
//   Pulses the PLL reset and qualifies the asynchronous PLL lock signal.
//   Releases the serializer (375 MHz) reset, then the pixel (75 MHz) reset.
//   On lock loss, re-asserts both resets and re-qualifies.
//   Runs only on clkin_25MHz, so it keeps working while the PLL outputs are unstable.
// PARAMETERS
//   PLL_RST_CYCLES      16     cycles pll_rst is held high per attempt (>=1)
//   LOCK_TIMEOUT        25000  cycles to wait for lock before re-resetting PLL (1 ms)
//   LOCK_STABLE_CYCLES  2500   consecutive locked cycles required before release (100 us)
//   RELEASE_GAP         8      cycles between ser_rst_n and pix_rst_n deassertion (>=1)
//   CNT_W               8      width of the diagnostic counters
// PORTS
//   clkin_25MHz    in   1      board clock, 25 MHz; sole clock of this block
//   rst_n          in   1      asynchronous, active-low reset
//   pll_locked     in   1      PLL LOCK, asynchronous to clkin_25MHz
//   pll_rst        out  1      drives PLL RST, active high
//   ser_rst_n      out  1      reset request for the 375 MHz serializer domain, active low
//   pix_rst_n      out  1      reset request for the 75 MHz pixel domain, active low
//   ready          out  1      high only in RUN
//   retry_cnt      out  CNT_W  lock-timeout re-reset attempts; saturating
//   lock_loss_cnt  out  CNT_W  lock drops after release; saturating
//   state_dbg      out  3      current state encoding
// BEHAVIOUR
//   Reset (rst_n=0, async) drives the following values:
//     state=PLL_RST, pll_rst=1, ser_rst_n=0, pix_rst_n=0, ready=0, counters=0, sync flops=0.
//   All outputs are registered. lock_s is pll_locked after a 2-FF synchronizer (2-cycle latency).
//   One shared cycle counter; it clears on every state change.
//   PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK with pll_rst=0.
//   WAIT_LOCK: lock_s is ignored on the first cycle.
//     lock_s=1 -> QUALIFY.
//     After LOCK_TIMEOUT cycles with no lock -> PLL_RST and retry_cnt++.
//   QUALIFY: lock_s=0 on any cycle -> WAIT_LOCK (timeout restarts, no count).
//     After LOCK_STABLE_CYCLES cycles of lock_s=1 -> RELEASE; ser_rst_n=1 on the same edge.
//   RELEASE: after RELEASE_GAP cycles -> RUN; pix_rst_n=1 and ready=1 on the same edge.
//   RUN: hold until lock_s=0.
//   Lock loss (lock_s=0 in RELEASE or RUN): on the next edge:
//     ser_rst_n=0, pix_rst_n=0, ready=0, lock_loss_cnt++, go to WAIT_LOCK.
//     The PLL is not re-reset unless the timeout later expires.
//   Invariants:
//     pix_rst_n=1 implies ser_rst_n=1.
//     pll_rst=1 implies both resets are asserted.
//     Resets are asserted within 3 cycles of the pll_locked fall.
//   Counters stop at 2^CNT_W-1 and do not wrap.
//   rst_n assertion mid-sequence aborts immediately to the reset values; there is no partial state.
//   Width rule: the cycle counter is $clog2 of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT,
//     LOCK_STABLE_CYCLES and RELEASE_GAP, plus 1.
//   Consumers re-synchronize ser_rst_n/pix_rst_n into their own clock
//     (assert asynchronously, deassert synchronously).
// STRUCTURE
//   Package clk_rst_pkg:
//     state enum: PLL_RST=0, WAIT_LOCK=1, QUALIFY=2, RELEASE=3, RUN=4.
//     Default timing constants.
//   Sub-module sync_2ff (2-flop synchronizer, async active-low clear) for pll_locked.
//     The same module is reused by the consumer-side reset bridges.
//   Everything else is one FSM plus counters in this file.
// TESTING  (PLL_RST_CYCLES=4, LOCK_TIMEOUT=50, LOCK_STABLE_CYCLES=20, RELEASE_GAP=3)
//   1. Release rst_n, pll_locked high from t=10 -> pll_rst high 4 cycles.
//      ser_rst_n rises 20 cycles after lock_s. pix_rst_n/ready rise 3 cycles later.
//      Counts stay 0.
//   2. pll_locked held low -> pll_rst re-pulses every 4+50 cycles.
//      retry_cnt=3 after 3 timeouts. Resets are never released.
//   3. pll_locked glitches low for 1 cycle at QUALIFY cycle 15 -> return to WAIT_LOCK.
//      Release occurs 20 cycles after re-lock. retry_cnt stays 0.
//   4. In RUN, drop pll_locked -> all three outputs low within 3 cycles and lock_loss_cnt=1.
//      Re-lock -> full re-qualify, no pll_rst pulse.
//   5. Assert rst_n in RELEASE -> ser_rst_n=0 and pll_rst=1 immediately (async).
//      Counters are 0.
//   6. CNT_W=2, force 5 lock losses -> lock_loss_cnt saturates at 3.
//   All tests check the invariants every cycle via assertions.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// ============================================================================
// Module : clk_rst_pkg
// Brief  : State encoding and default timing for the PLL reset sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package clk_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        QUALIFY   = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_e;

    // Defaults sized for a 25 MHz reference clock.
    localparam int unsigned DEF_PLL_RST_CYCLES     = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT       = 25000;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 2500;
    localparam int unsigned DEF_RELEASE_GAP        = 8;
    localparam int unsigned DEF_CNT_W              = 8;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Two-flop synchronizer with asynchronous active-low clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module : pll_reset_sequencer
// Brief  : Pulses PLL reset, qualifies lock, then releases serializer and
//          pixel resets in order; re-sequences on lock loss.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pll_reset_sequencer
    import clk_rst_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned RELEASE_GAP        = DEF_RELEASE_GAP,
    parameter int unsigned CNT_W              = DEF_CNT_W
) (
    input  logic             clkin_25MHz,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             ser_rst_n,
    output logic             pix_rst_n,
    output logic             ready,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]       state_dbg
);

    localparam int unsigned CYC_W =
        $clog2(max4(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES, RELEASE_GAP)) + 1;

    // Terminal counts: the shared counter starts at zero on each state entry.
    localparam logic [CYC_W-1:0] PLL_RST_LAST = CYC_W'(PLL_RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] GAP_LAST     = CYC_W'(RELEASE_GAP - 1);

    logic             lock_s;
    state_e           state_q,     state_d;
    logic [CYC_W-1:0] cnt_q,       cnt_d;
    logic [CNT_W-1:0] retry_q,     retry_d;
    logic [CNT_W-1:0] loss_q,      loss_d;
    logic             pll_rst_q,   pll_rst_d;
    logic             ser_rst_n_q, ser_rst_n_d;
    logic             pix_rst_n_q, pix_rst_n_d;
    logic             ready_q,     ready_d;

    sync_2ff u_lock_sync (
        .clk_i  (clkin_25MHz),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (lock_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // First cycle after entry ignores lock_s so a stale lock is not trusted.
                if (lock_s && (cnt_q != '0)) begin
                    state_d = QUALIFY;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = PLL_RST;
                    retry_d = (retry_q == '1) ? retry_q : retry_q + CNT_W'(1);
                end
            end
            QUALIFY: begin
                if (!lock_s)                    state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_d = RELEASE;
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    loss_d  = (loss_q == '1) ? loss_q : loss_q + CNT_W'(1);
                end else if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    loss_d  = (loss_q == '1) ? loss_q : loss_q + CNT_W'(1);
                end
            end
            default: state_d = PLL_RST;
        endcase

        if (state_d != state_q)  cnt_d = '0;
        else if (state_q == RUN) cnt_d = cnt_q;
        else                     cnt_d = cnt_q + CYC_W'(1);

        // Outputs follow the next state so they change on the transition edge.
        pll_rst_d   = (state_d == PLL_RST);
        ser_rst_n_d = (state_d == RELEASE) || (state_d == RUN);
        pix_rst_n_d = (state_d == RUN);
        ready_d     = (state_d == RUN);
    end

    always_ff @(posedge clkin_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            ser_rst_n_q <= 1'b0;
            pix_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            ser_rst_n_q <= ser_rst_n_d;
            pix_rst_n_q <= pix_rst_n_d;
            ready_q     <= ready_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign ser_rst_n     = ser_rst_n_q;
    assign pix_rst_n     = pix_rst_n_q;
    assign ready         = ready_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;
    assign state_dbg     = state_q;

endmodule

`default_nettype wire
